// File: rtl/hd_access_sequencer.sv
// HD syscall sequencer: stalls the CPU while it runs one req/ready access to the
// HD model, captures read data, pulses write-back/done, and bounds each access.
module hd_access_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hd_ready,
  input  logic [DATA_W-1:0] hd_rdata,
  output logic              hd_req,
  output logic              hd_we,
  output logic [ADDR_W-1:0] hd_addr,
  output logic [DATA_W-1:0] hd_wdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              wb_en,
  output logic              stall,
  output logic              done,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              wb_en_reg, wb_en_next;
  logic              done_reg, done_next;
  logic              terr_reg, terr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      wb_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      terr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      wb_en_reg <= wb_en_next;
      done_reg  <= done_next;
      terr_reg  <= terr_next;
    end
  end

  // done/wb_en are computed on the transition so they are high exactly in DONE/ERR.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    terr_next  = terr_reg;
    wb_en_next = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_wr || start_rd) begin
          addr_next  = addr;
          wdata_next = wdata;
          we_next    = start_wr;
          req_next   = 1'b1;
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (hd_ready) begin
          req_next = 1'b0;
          if (!we_reg) rdata_next = hd_rdata;
          done_next  = 1'b1;
          wb_en_next = !we_reg;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          req_next   = 1'b0;
          terr_next  = 1'b1;
          rdata_next = '0;
          done_next  = 1'b1;
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Released in DONE/ERR so the PC moves on and the syscall is not retriggered.
  assign stall = ((state_reg == IDLE) && (start_rd || start_wr)) || (state_reg == REQ);

  assign hd_req      = req_reg;
  assign hd_we       = we_reg;
  assign hd_addr     = addr_reg;
  assign hd_wdata    = wdata_reg;
  assign rdata_out   = rdata_reg;
  assign wb_en       = wb_en_reg;
  assign done        = done_reg;
  assign timeout_err = terr_reg;

endmodule
